adc_frame_capture: RTL and testbench
====================================

# adc_frame_capture

Frame controller and serial deserializer directly downstream of the ADC clock generator. On a frame start it requests the 10 MHz ADC clock, shifts the ADC serial data in on every ADC-clock high phase, and emits parallel samples. After a fixed number of samples it pulses the end-of-frame reset that stops the ADC clock. Runs entirely in the 20 MHz domain and feeds the sample path toward the SPI/MEMS readout.

## Interface
- SAMPLE_WIDTH, 16: bits per ADC sample, MSB first (2..32).
- SAMPLES_PER_FRAME, 8: samples per frame (1..255).
- SKIP_BITS, 0: leading ADC bits discarded once per frame, before the first sample (0..15).

- clk_20MHz_i  in  1: system clock, 20 MHz; all logic on its rising edge.
- reset  in  1: asynchronous, active-high; forces IDLE and all outputs to reset values.
- frame_start_i  in  1: one-cycle start request; ignored unless in IDLE.
- frame_abort_i  in  1: level; terminates the frame early (see END).
- adc_data_i  in  1: ADC serial data, stable during ADC-clock high phase.
- clk_10MHz_i  in  1: ADC clock fed back from the clock generator.
- clk_ADC_valid_i  in  1: clock-generator "clock running" flag.
- clock_to_ADC_req  out  1: one-cycle request to start the ADC clock.
- reset_after_end_frame  out  1: one-cycle pulse that stops the ADC clock.
- sample_o  out  SAMPLE_WIDTH: last completed sample; holds until the next one.
- sample_valid_o  out  1: one-cycle strobe, sample_o updated this cycle.
- sample_index_o  out  8: index 0..SAMPLES_PER_FRAME-1 of sample_o.
- frame_done_o  out  1: one-cycle pulse when a frame completes normally.
- busy_o  out  1: high in every state except IDLE.

## Operation
- Bit strobe: `strobe = clk_ADC_valid_i && clk_10MHz_i`, sampled at the rising edge of clk_20MHz_i. It is acted on only in CAPTURE.
- States: IDLE, REQ, CAPTURE, END.
- IDLE: on frame_start_i, assert clock_to_ADC_req for one cycle, clear all counters, and go to REQ.
- REQ: wait for clk_ADC_valid_i=1, then go to CAPTURE. frame_abort_i goes to END.
- CAPTURE:
  - Each strobe either decrements the skip counter (while it is nonzero) or shifts adc_data_i into the LSB of the shift register.
  - When bit_cnt reaches SAMPLE_WIDTH-1 on a strobe, the shifted word is loaded into sample_o, sample_valid_o pulses, sample_index_o takes the current sample_cnt, and bit_cnt returns to 0.
  - On the strobe that completes sample SAMPLES_PER_FRAME-1, go to END with frame_done pending.
- END:
  - Asserts reset_after_end_frame for exactly one cycle, on entry.
  - frame_done_o pulses in the same cycle, but only for normal completion, not abort.
  - Waits for clk_ADC_valid_i=0, then returns to IDLE.
  - Strobes in END are ignored, including the residual high phase of the ADC clock.
- Abort in CAPTURE: a partial word is discarded. sample_o is not updated and no sample_valid_o is generated.
- Abort plus completing strobe in the same cycle: the sample is emitted and the frame is treated as complete (frame_done_o=1).
- frame_start_i while busy: ignored, not queued.
- Counter widths: bit_cnt is 5 bits, skip counter 4 bits, sample_cnt 8 bits. No wrap within a frame, because the frame ends at SAMPLES_PER_FRAME.

## Timing
- Reset values: every output 0, state IDLE, shift register and counters 0.
- clock_to_ADC_req is registered and high the cycle after frame_start_i.
- Clock generator latency: clk_ADC_valid_i rises 1 cycle after the request; clk_10MHz_i first goes high 1 cycle after that.
- First strobe: 3 cycles after clock_to_ADC_req is high. Strobes then repeat every 2 cycles.
- Per-sample latency: sample_valid_o is high the cycle after the final-bit strobe edge.
- Frame period: SKIP_BITS + SAMPLE_WIDTH×SAMPLES_PER_FRAME strobes, i.e. 2 cycles each.
- reset_after_end_frame is high the cycle after the last strobe. clk_ADC_valid_i falls 1 cycle later, and the block is back in IDLE 1 cycle after that.
- Reset mid-frame: all outputs go to 0 immediately. No reset_after_end_frame is issued; the global reset stops the clock generator.

## Test plan
- Single frame, defaults. Serial pattern gives samples 0xA5C3, 0x0001, … 0xFFFF -> 8 sample_valid_o pulses 2×16 cycles apart, index 0..7, matching sample_o values, then one reset_after_end_frame + frame_done_o, then busy_o=0.
- SKIP_BITS=3, SAMPLE_WIDTH=8, SAMPLES_PER_FRAME=2. Stream 111_10110011_01010101 -> samples 0xB3 then 0x55, leading ones discarded.
- Abort after 20 strobes, defaults -> one sample emitted (index 0), partial word dropped, reset_after_end_frame pulses once, frame_done_o stays 0.
- frame_start_i pulsed in CAPTURE and in END -> ignored; exactly one clock_to_ADC_req per frame.
- Async reset asserted mid-sample, between 20 MHz edges -> all outputs 0 immediately. A new frame_start_i after release runs a clean frame with index restarting at 0.
- Clock generator slow to respond (clk_ADC_valid_i delayed 10 cycles) -> block holds in REQ with no strobes acted on, then captures normally.

Source files
------------

// File: rtl/adc_frame_capture_if.sv
// Frame-capture bus: frame control, ADC serial/clock feedback and parallel sample outputs.
// The master drives the frame and ADC-side inputs. The slave (the capture block) drives the results.
interface adc_frame_capture_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    frame_start_i;
  logic                    frame_abort_i;
  logic                    adc_data_i;
  logic                    clk_10MHz_i;
  logic                    clk_ADC_valid_i;
  logic                    clock_to_ADC_req;
  logic                    reset_after_end_frame;
  logic [SAMPLE_WIDTH-1:0] sample_o;
  logic                    sample_valid_o;
  logic [7:0]              sample_index_o;
  logic                    frame_done_o;
  logic                    busy_o;

  modport master (
    output frame_start_i, frame_abort_i, adc_data_i, clk_10MHz_i, clk_ADC_valid_i,
    input  clock_to_ADC_req, reset_after_end_frame, sample_o, sample_valid_o,
           sample_index_o, frame_done_o, busy_o
  );

  modport slave (
    input  frame_start_i, frame_abort_i, adc_data_i, clk_10MHz_i, clk_ADC_valid_i,
    output clock_to_ADC_req, reset_after_end_frame, sample_o, sample_valid_o,
           sample_index_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/adc_frame_capture.sv
// Serial ADC frame capture: requests the ADC clock, deserializes MSB-first words on ADC-clock
// high phases, and closes each frame with a one-cycle clock-stop pulse.
module adc_frame_capture #(
  parameter int SAMPLE_WIDTH      = 16,
  parameter int SAMPLES_PER_FRAME = 8,
  parameter int SKIP_BITS         = 0
) (
  input logic                clk_20MHz_i,
  input logic                reset,
  adc_frame_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2,
    END     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [3:0]              skip_cnt_q, skip_cnt_d;
  logic [7:0]              sample_cnt_q, sample_cnt_d;
  logic [7:0]              sample_index_q, sample_index_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    clk_req_q, clk_req_d;
  logic                    eof_rst_q, eof_rst_d;
  logic                    frame_done_q, frame_done_d;

  logic                    strobe;
  logic                    last_bit;
  logic                    last_sample;
  logic [SAMPLE_WIDTH-1:0] shift_next;

  assign strobe      = bus.clk_ADC_valid_i && bus.clk_10MHz_i;
  assign last_bit    = (bit_cnt_q == 5'(SAMPLE_WIDTH - 1));
  assign last_sample = (sample_cnt_q == 8'(SAMPLES_PER_FRAME - 1));
  assign shift_next  = (shift_q << 1) | {{(SAMPLE_WIDTH-1){1'b0}}, bus.adc_data_i};

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    sample_d       = sample_q;
    bit_cnt_d      = bit_cnt_q;
    skip_cnt_d     = skip_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    sample_index_d = sample_index_q;
    sample_valid_d = 1'b0;
    clk_req_d      = 1'b0;
    eof_rst_d      = 1'b0;
    frame_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.frame_start_i) begin
          clk_req_d    = 1'b1;
          shift_d      = '0;
          bit_cnt_d    = 5'd0;
          skip_cnt_d   = 4'(SKIP_BITS);
          sample_cnt_d = 8'd0;
          state_d      = REQ;
        end
      end

      REQ: begin
        if (bus.frame_abort_i) begin
          eof_rst_d = 1'b1;
          state_d   = END;
        end else if (bus.clk_ADC_valid_i) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        if (strobe) begin
          if (skip_cnt_q != 4'd0) begin
            skip_cnt_d = skip_cnt_q - 4'd1;
          end else begin
            shift_d = shift_next;
            if (last_bit) begin
              bit_cnt_d      = 5'd0;
              sample_d       = shift_next;
              sample_valid_d = 1'b1;
              sample_index_d = sample_cnt_q;
              sample_cnt_d   = sample_cnt_q + 8'd1;
              if (last_sample) begin
                eof_rst_d    = 1'b1;
                frame_done_d = 1'b1;
                state_d      = END;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        // A completing final strobe wins over abort; otherwise abort drops the partial word.
        if (bus.frame_abort_i && (state_d != END)) begin
          eof_rst_d = 1'b1;
          state_d   = END;
        end
      end

      END: begin
        if (!bus.clk_ADC_valid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_20MHz_i or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      sample_q       <= '0;
      bit_cnt_q      <= 5'd0;
      skip_cnt_q     <= 4'd0;
      sample_cnt_q   <= 8'd0;
      sample_index_q <= 8'd0;
      sample_valid_q <= 1'b0;
      clk_req_q      <= 1'b0;
      eof_rst_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      sample_q       <= sample_d;
      bit_cnt_q      <= bit_cnt_d;
      skip_cnt_q     <= skip_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      sample_index_q <= sample_index_d;
      sample_valid_q <= sample_valid_d;
      clk_req_q      <= clk_req_d;
      eof_rst_q      <= eof_rst_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.clock_to_ADC_req      = clk_req_q;
  assign bus.reset_after_end_frame = eof_rst_q;
  assign bus.sample_o              = sample_q;
  assign bus.sample_valid_o        = sample_valid_q;
  assign bus.sample_index_o        = sample_index_q;
  assign bus.frame_done_o          = frame_done_q;
  assign bus.busy_o                = (state_q != IDLE);

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: two configurations driven by a clock-generator/ADC model,
// with captured samples compared against words sliced MSB-first from the serial stream.
module tb_adc_frame_capture;

  localparam int SW [2]  = '{16, 8};
  localparam int SKP[2]  = '{0, 3};
  localparam int SPF[2]  = '{8, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #25 clk = ~clk;

  logic [1:0] start_r = '0, abort_r = '0, data_r = '0, c10_r = '0, cvld_r = '0;
  logic [1:0] req_w, eof_w, done_w, busy_w, svld_w;
  logic [7:0]  sidx_w [2];
  logic [31:0] sdat_w [2];

  adc_frame_capture_if #(.SAMPLE_WIDTH(16)) ifa ();
  adc_frame_capture_if #(.SAMPLE_WIDTH(8))  ifb ();

  adc_frame_capture #(.SAMPLE_WIDTH(16), .SAMPLES_PER_FRAME(8), .SKIP_BITS(0)) dut_a (
    .clk_20MHz_i(clk), .reset(rst), .bus(ifa));
  adc_frame_capture #(.SAMPLE_WIDTH(8), .SAMPLES_PER_FRAME(2), .SKIP_BITS(3)) dut_b (
    .clk_20MHz_i(clk), .reset(rst), .bus(ifb));

  assign ifa.frame_start_i   = start_r[0];
  assign ifa.frame_abort_i   = abort_r[0];
  assign ifa.adc_data_i      = data_r[0];
  assign ifa.clk_10MHz_i     = c10_r[0];
  assign ifa.clk_ADC_valid_i = cvld_r[0];
  assign ifb.frame_start_i   = start_r[1];
  assign ifb.frame_abort_i   = abort_r[1];
  assign ifb.adc_data_i      = data_r[1];
  assign ifb.clk_10MHz_i     = c10_r[1];
  assign ifb.clk_ADC_valid_i = cvld_r[1];

  assign req_w  = {ifb.clock_to_ADC_req, ifa.clock_to_ADC_req};
  assign eof_w  = {ifb.reset_after_end_frame, ifa.reset_after_end_frame};
  assign done_w = {ifb.frame_done_o, ifa.frame_done_o};
  assign busy_w = {ifb.busy_o, ifa.busy_o};
  assign svld_w = {ifb.sample_valid_o, ifa.sample_valid_o};
  assign sidx_w[0] = ifa.sample_index_o;
  assign sidx_w[1] = ifb.sample_index_o;
  assign sdat_w[0] = 32'(ifa.sample_o);
  assign sdat_w[1] = 32'(ifb.sample_o);

  int vectors = 0;
  int miscompares = 0;

  // Serial stream per instance: bits[i][k] is presented on the k-th ADC-clock high phase.
  bit bits [2][1024];
  int slow [2] = '{0, 0};

  // Clock generator + ADC model, updated on the falling edge so the DUT sees stable inputs.
  int rise_cnt [2] = '{0, 0};
  bit fall_pend [2] = '{0, 0};
  int hcnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cvld_r[i] = 1'b0; c10_r[i] = 1'b0; data_r[i] = 1'b0;
        rise_cnt[i] = 0; fall_pend[i] = 1'b0; hcnt[i] = 0;
      end else begin
        if (fall_pend[i]) begin
          cvld_r[i] = 1'b0; c10_r[i] = 1'b0; fall_pend[i] = 1'b0;
        end else if (cvld_r[i]) begin
          c10_r[i] = ~c10_r[i];
          if (c10_r[i]) begin
            data_r[i] = (hcnt[i] < 1024) ? bits[i][hcnt[i]] : 1'b0;
            hcnt[i]++;
          end
        end
        if (rise_cnt[i] > 0) begin
          rise_cnt[i]--;
          if (rise_cnt[i] == 0) begin cvld_r[i] = 1'b1; hcnt[i] = 0; end
        end
        if (req_w[i]) rise_cnt[i] = 1 + slow[i];
        if (eof_w[i]) fall_pend[i] = 1'b1;
      end
    end
  end

  // Output monitor: logs every strobe/pulse with the cycle it was seen in.
  int cyc = 0;
  int nsv [2] = '{0, 0};
  int eof_cnt [2] = '{0, 0}, done_cnt [2] = '{0, 0}, req_cnt [2] = '{0, 0};
  int eof_cyc [2] = '{0, 0}, req_cyc [2] = '{0, 0};
  longint obs_dat [2][1024];
  int obs_idx [2][1024];
  int obs_cyc [2][1024];

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (svld_w[i] && nsv[i] < 1024) begin
        obs_dat[i][nsv[i]] = longint'(sdat_w[i]);
        obs_idx[i][nsv[i]] = int'(sidx_w[i]);
        obs_cyc[i][nsv[i]] = cyc;
        nsv[i]++;
      end
      if (eof_w[i])  begin eof_cnt[i]++; eof_cyc[i] = cyc; end
      if (done_w[i]) done_cnt[i]++;
      if (req_w[i])  begin req_cnt[i]++; req_cyc[i] = cyc; end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic string pfx(input int i);
    return (i == 0) ? "A." : "B.";
  endfunction

  function automatic longint exp_word(input int i, input int s);
    longint w = 0;
    for (int k = 0; k < SW[i]; k++)
      w = (w << 1) | longint'(bits[i][SKP[i] + s * SW[i] + k]);
    return w;
  endfunction

  task automatic fill_random(input int i);
    for (int k = 0; k < 1024; k++) bits[i][k] = 1'($urandom_range(0, 1));
  endtask

  task automatic set_word(input int i, input int s, input logic [31:0] w);
    for (int k = 0; k < SW[i]; k++) bits[i][SKP[i] + s * SW[i] + k] = w[SW[i] - 1 - k];
  endtask

  task automatic check_zero(input int i, input string what);
    chk({pfx(i), what, "_req"},   longint'(req_w[i]),  0);
    chk({pfx(i), what, "_eof"},   longint'(eof_w[i]),  0);
    chk({pfx(i), what, "_done"},  longint'(done_w[i]), 0);
    chk({pfx(i), what, "_busy"},  longint'(busy_w[i]), 0);
    chk({pfx(i), what, "_svld"},  longint'(svld_w[i]), 0);
    chk({pfx(i), what, "_sidx"},  longint'(sidx_w[i]), 0);
    chk({pfx(i), what, "_sdat"},  longint'(sdat_w[i]), 0);
  endtask

  // One frame: abort_n>0 raises abort once the generator has presented abort_n bits,
  // in the low phase (abort_hi=0) or in the high phase of that bit (abort_hi=1).
  task automatic run_frame(input int i, input int abort_n, input bit abort_hi,
                           input int slow_n, input bit poke);
    int b_sv, b_eof, b_done, b_req, t, n_exp, total;
    bit poked1, poked2, aborted, complete;
    b_sv = nsv[i]; b_eof = eof_cnt[i]; b_done = done_cnt[i]; b_req = req_cnt[i];
    poked1 = 0; poked2 = 0; aborted = 0;
    total = SKP[i] + SW[i] * SPF[i];
    slow[i] = slow_n;
    @(negedge clk); #1; start_r[i] = 1'b1;
    @(negedge clk); #1; start_r[i] = 1'b0;
    chk({pfx(i), "busy_on"}, longint'(busy_w[i]), 1);
    t = 0;
    while (busy_w[i] && t < 3000) begin
      @(negedge clk); #1; t++;
      start_r[i] = 1'b0;
      abort_r[i] = 1'b0;
      if (poke && !poked1 && (nsv[i] - b_sv) == 1) begin start_r[i] = 1'b1; poked1 = 1; end
      if (poke && !poked2 && (eof_cnt[i] - b_eof) == 1) begin start_r[i] = 1'b1; poked2 = 1; end
      if (abort_n > 0 && !aborted && hcnt[i] == abort_n && c10_r[i] == abort_hi) begin
        abort_r[i] = 1'b1; aborted = 1;
      end
    end
    start_r[i] = 1'b0;
    abort_r[i] = 1'b0;
    chk({pfx(i), "frame_ends"}, longint'(t < 3000), 1);

    complete = (abort_n == 0) || (abort_hi && abort_n >= total);
    if (complete)             n_exp = SPF[i];
    else if (abort_n < SKP[i]) n_exp = 0;
    else                       n_exp = (abort_n - SKP[i]) / SW[i];

    chk({pfx(i), "nsamples"},   longint'(nsv[i] - b_sv), longint'(n_exp));
    for (int s = 0; s < n_exp && s < nsv[i] - b_sv; s++) begin
      chk({pfx(i), $sformatf("sample%0d", s)}, obs_dat[i][b_sv + s], exp_word(i, s));
      chk({pfx(i), $sformatf("index%0d", s)},  longint'(obs_idx[i][b_sv + s]), longint'(s));
      if (s > 0)
        chk({pfx(i), "spacing"}, longint'(obs_cyc[i][b_sv + s] - obs_cyc[i][b_sv + s - 1]),
            longint'(2 * SW[i]));
    end
    if (n_exp > 0 && nsv[i] > b_sv) begin
      chk({pfx(i), "first_latency"}, longint'(obs_cyc[i][b_sv] - req_cyc[i]),
          longint'(1 + slow_n + 2 * (SKP[i] + SW[i])));
      chk({pfx(i), "sample_hold"}, longint'(sdat_w[i]), exp_word(i, n_exp - 1));
    end
    if (complete && nsv[i] > b_sv)
      chk({pfx(i), "eof_timing"}, longint'(eof_cyc[i]), longint'(obs_cyc[i][nsv[i] - 1]));
    chk({pfx(i), "eof_pulses"}, longint'(eof_cnt[i] - b_eof),   1);
    chk({pfx(i), "frame_done"}, longint'(done_cnt[i] - b_done), longint'(complete));
    chk({pfx(i), "req_pulses"}, longint'(req_cnt[i] - b_req),   1);
    repeat (3) @(negedge clk);
    #1;
    chk({pfx(i), "idle_after"}, longint'(busy_w[i]), 0);
    chk({pfx(i), "no_restart"}, longint'(req_cnt[i] - b_req), 1);
  endtask

  // Reset asserted between clock edges partway through the second sample.
  task automatic reset_mid(input int i);
    int b_sv, t;
    b_sv = nsv[i];
    fill_random(i);
    bits[i][SKP[i]] = 1'b1;
    slow[i] = 0;
    @(negedge clk); #1; start_r[i] = 1'b1;
    @(negedge clk); #1; start_r[i] = 1'b0;
    t = 0;
    while (nsv[i] == b_sv && t < 1000) begin @(negedge clk); #1; t++; end
    chk({pfx(i), "rstmid_reached"}, longint'(t < 1000), 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_zero(i, "rstmid");
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, total;
    repeat (3) @(negedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known words on the default configuration.
    fill_random(0);
    set_word(0, 0, 32'hA5C3);
    set_word(0, 1, 32'h0001);
    set_word(0, 7, 32'hFFFF);
    run_frame(0, 0, 1'b0, 0, 1'b0);

    // Skip-bit configuration with the stream 111_10110011_01010101.
    fill_random(1);
    for (int k = 0; k < 3; k++) bits[1][k] = 1'b1;
    set_word(1, 0, 32'hB3);
    set_word(1, 1, 32'h55);
    run_frame(1, 0, 1'b0, 0, 1'b0);

    // Abort after 20 strobes: one sample survives, the partial one is dropped.
    fill_random(0);
    run_frame(0, 20, 1'b0, 0, 1'b0);

    // Abort coinciding with the completing final strobe counts as a normal frame.
    fill_random(1);
    run_frame(1, SKP[1] + SW[1] * SPF[1], 1'b1, 0, 1'b0);

    // Extra frame_start pulses in CAPTURE and END are ignored.
    fill_random(0);
    run_frame(0, 0, 1'b0, 0, 1'b1);

    // Clock generator slow to respond.
    fill_random(0);
    run_frame(0, 0, 1'b0, 10, 1'b0);

    // Async reset mid-sample, then a clean frame restarting at index 0.
    reset_mid(0);
    repeat (2) @(negedge clk);
    fill_random(0);
    run_frame(0, 0, 1'b0, 0, 1'b0);

    // Randomized frames on both configurations.
    for (int r = 0; r < 8; r++) begin
      i = r % 2;
      total = SKP[i] + SW[i] * SPF[i];
      fill_random(i);
      if (r % 3 == 2)
        run_frame(i, $urandom_range(1, total - 1), 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else
        run_frame(i, 0, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
